// File: rtl/id_pkg.sv
// Shared definitions for the decode stage of the 8-bit, 16-bit-instruction pipeline.
// Contents: opcode encodings, instruction field bit positions, the NOP encoding and
// small decode helpers used by id_stage.
package id_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SL   = 4'd6;
    localparam logic [3:0] OP_SR   = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BR   = 4'd12;

    // Instruction layout: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [5:0] imm6.
    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 9;
    localparam int unsigned RS_HI  = 8;
    localparam int unsigned RS_LO  = 6;
    localparam int unsigned RT_HI  = 5;
    localparam int unsigned RT_LO  = 3;
    localparam int unsigned IMM_HI = 5;
    localparam int unsigned IMM_LO = 0;

    localparam logic [15:0] NOP_INSTR = 16'b0;

    // Map unassigned opcodes onto NOP so downstream logic only ever sees legal ops.
    function automatic logic [3:0] legal_op(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR,
            OP_ADDI, OP_LD, OP_ST, OP_BR: res = op;
            default:                      res = OP_NOP;
        endcase
        return res;
    endfunction

    // Register-register ALU ops read rt as a second source.
    function automatic logic is_rr_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SR);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8-entry register file for the decode stage.
// Ports: clk/rst (async active-high reset clears R1-R7), three combinational read ports
// (ra*_i -> rd*_o), one write port (we_i, wa_i, wd_i) committed at posedge.
// R0 always reads 0 and ignores writes. A read of the address being written this cycle
// returns the write data (write-through bypass).
module reg_file #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ra1_i,
    input  logic [2:0]        ra2_i,
    input  logic [2:0]        ra3_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] rd3_o,
    input  logic              we_i,
    input  logic [2:0]        wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    function automatic logic [DATA_W-1:0] read_port(input logic [2:0] addr);
        logic [DATA_W-1:0] res;
        if (addr == 3'd0) begin
            res = '0;
        end else if (we_i && (wa_i == addr)) begin
            res = wd_i;
        end else begin
            res = regs_q[addr];
        end
        return res;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (we_i && (wa_i != 3'd0)) begin
            regs_d[wa_i] = wd_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1_o = read_port(ra1_i);
        rd2_o = read_port(ra2_i);
        rd3_o = read_port(ra3_i);
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, hazard detection, branch resolution in ID,
// and the ID/EX register.
// Ports: pc/instr from fetch; stall, branch_taken, branch_offset_imm back to fetch
// (combinational); ex_*/mem_* hazard info from later stages; wb_* write-back port;
// id_ex_* registered decode results for EX.
module id_stage
    import id_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic [15:0]       instr,
    output logic              stall,
    output logic              branch_taken,
    output logic [5:0]        branch_offset_imm,
    input  logic [2:0]        ex_dest,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [2:0]        mem_dest,
    input  logic              mem_reg_write,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [3:0]        id_ex_op,
    output logic [2:0]        id_ex_rd,
    output logic [2:0]        id_ex_rs,
    output logic [2:0]        id_ex_rt,
    output logic [DATA_W-1:0] id_ex_val1,
    output logic [DATA_W-1:0] id_ex_val2,
    output logic [DATA_W-1:0] id_ex_st_val,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic              id_ex_mem_write,
    output logic [PC_W-1:0]   id_ex_pc
);

    typedef struct packed {
        logic [3:0]        op;
        logic [2:0]        rd;
        logic [2:0]        rs;
        logic [2:0]        rt;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_val;
        logic [DATA_W-1:0] imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [PC_W-1:0]   pc;
    } id_ex_t;

    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [15:0]     ifid_instr_q, ifid_instr_d;
    id_ex_t          idex_q, idex_d, dec;

    logic [3:0]        op;
    logic [2:0]        rd, rs, rt;
    logic [5:0]        imm6;
    logic [DATA_W-1:0] rs_val, rt_val, st_val;
    logic              is_rr, is_st, is_ld, is_br;
    logic              load_use, br_hazard;

    assign op   = legal_op(ifid_instr_q[OP_HI:OP_LO]);
    assign rd   = ifid_instr_q[RD_HI:RD_LO];
    assign rs   = ifid_instr_q[RS_HI:RS_LO];
    assign rt   = ifid_instr_q[RT_HI:RT_LO];
    assign imm6 = ifid_instr_q[IMM_HI:IMM_LO];

    assign is_rr = is_rr_op(op);
    assign is_st = (op == OP_ST);
    assign is_ld = (op == OP_LD);
    assign is_br = (op == OP_BR);

    // ST carries its store-data register in the rd field, hence the third read port.
    reg_file #(
        .DATA_W (DATA_W)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .ra3_i (rd),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .rd3_o (st_val),
        .we_i  (wb_en),
        .wa_i  (wb_addr),
        .wd_i  (wb_data)
    );

    // A load in EX cannot forward in time; hold ID if any real source matches its dest.
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_dest != 3'd0) && (op != OP_NOP)) begin
            load_use = (ex_dest == rs) || (is_rr && (ex_dest == rt)) ||
                       (is_st && (ex_dest == rd));
        end
    end

    // Branches compare in ID, so any pending producer of rs in EX or MEM must drain first.
    assign br_hazard = is_br && (rs != 3'd0) &&
                       ((ex_reg_write && (ex_dest == rs)) || (mem_reg_write && (mem_dest == rs)));

    assign stall             = load_use || br_hazard;
    assign branch_taken      = is_br && (rs_val == '0) && !stall;
    assign branch_offset_imm = is_br ? imm6 : 6'd0;

    always_comb begin
        dec           = '0;
        dec.op        = op;
        dec.rd        = rd;
        dec.rs        = rs;
        dec.rt        = rt;
        dec.val1      = rs_val;
        dec.val2      = rt_val;
        dec.st_val    = st_val;
        dec.imm       = {{(DATA_W - 6){imm6[5]}}, imm6};
        dec.reg_write = (is_rr || (op == OP_ADDI) || is_ld) && (rd != 3'd0);
        dec.mem_read  = is_ld;
        dec.mem_write = is_st;
        dec.pc        = ifid_pc_q;
    end

    always_comb begin
        ifid_pc_d    = pc;
        ifid_instr_d = instr;
        idex_d       = dec;
        if (stall) begin
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = ifid_instr_q;
            idex_d       = '0;
        end else if (branch_taken) begin
            // Squash the wrong-path fetch; the BR itself moves on with no side effects.
            ifid_pc_d        = ifid_pc_q;
            ifid_instr_d     = NOP_INSTR;
            idex_d.reg_write = 1'b0;
            idex_d.mem_read  = 1'b0;
            idex_d.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            idex_q       <= '0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            idex_q       <= idex_d;
        end
    end

    assign id_ex_op        = idex_q.op;
    assign id_ex_rd        = idex_q.rd;
    assign id_ex_rs        = idex_q.rs;
    assign id_ex_rt        = idex_q.rt;
    assign id_ex_val1      = idex_q.val1;
    assign id_ex_val2      = idex_q.val2;
    assign id_ex_st_val    = idex_q.st_val;
    assign id_ex_imm       = idex_q.imm;
    assign id_ex_reg_write = idex_q.reg_write;
    assign id_ex_mem_read  = idex_q.mem_read;
    assign id_ex_mem_write = idex_q.mem_write;
    assign id_ex_pc        = idex_q.pc;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, load-use and branch hazards, branch flush,
// register-file bypass, R0 handling and asynchronous reset.
module tb_id_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc;
    logic [15:0] instr;
    logic       stall, branch_taken;
    logic [5:0] branch_offset_imm;
    logic [2:0] ex_dest, mem_dest, wb_addr;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_en;
    logic [7:0] wb_data;
    logic [3:0] id_ex_op;
    logic [2:0] id_ex_rd, id_ex_rs, id_ex_rt;
    logic [7:0] id_ex_val1, id_ex_val2, id_ex_st_val, id_ex_imm, id_ex_pc;
    logic       id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_stage #(
        .DATA_W (8),
        .PC_W   (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .instr             (instr),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_offset_imm (branch_offset_imm),
        .ex_dest           (ex_dest),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_read       (ex_mem_read),
        .mem_dest          (mem_dest),
        .mem_reg_write     (mem_reg_write),
        .wb_en             (wb_en),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .id_ex_op          (id_ex_op),
        .id_ex_rd          (id_ex_rd),
        .id_ex_rs          (id_ex_rs),
        .id_ex_rt          (id_ex_rt),
        .id_ex_val1        (id_ex_val1),
        .id_ex_val2        (id_ex_val2),
        .id_ex_st_val      (id_ex_st_val),
        .id_ex_imm         (id_ex_imm),
        .id_ex_reg_write   (id_ex_reg_write),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_mem_write   (id_ex_mem_write),
        .id_ex_pc          (id_ex_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [7:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc = 8'h00; instr = 16'h0000;
        ex_dest = 3'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_dest = 3'd0; mem_reg_write = 1'b0;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
        #12;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_br_taken", branch_taken, 0);
        check_eq("rst_br_off", branch_offset_imm, 0);
        check_eq("rst_op", id_ex_op, 0);
        check_eq("rst_regwr", id_ex_reg_write, 0);
        rst = 1'b0;

        // ADDI R1 = 5
        instr = 16'h9205; pc = 8'h10;
        tick();
        instr = 16'h0000; pc = 8'h11;
        #1;
        check_eq("addi_stall", stall, 0);
        tick();
        check_eq("addi_op", id_ex_op, 9);
        check_eq("addi_rd", id_ex_rd, 1);
        check_eq("addi_rs", id_ex_rs, 0);
        check_eq("addi_imm", id_ex_imm, 8'h05);
        check_eq("addi_regwr", id_ex_reg_write, 1);
        check_eq("addi_pc", id_ex_pc, 8'h10);

        // Unassigned opcode 15 decodes as NOP
        instr = 16'hF2C5;
        tick();
        instr = 16'h0000;
        tick();
        check_eq("bad_op", id_ex_op, 0);
        check_eq("bad_op_regwr", id_ex_reg_write, 0);

        // Load-use: LD R6,14(R7) in ID, LD R7 in EX
        wb_write(3'd7, 8'h33);
        instr = 16'hADCE; pc = 8'h20;
        tick();
        instr = 16'h9205; pc = 8'h21;
        ex_mem_read = 1'b1; ex_dest = 3'd7;
        #1;
        check_eq("lu_stall", stall, 1);
        check_eq("lu_no_branch", branch_taken, 0);
        tick();
        check_eq("lu_bubble_op", id_ex_op, 0);
        check_eq("lu_bubble_rd", id_ex_mem_read, 0);
        check_eq("lu_bubble_wr", id_ex_reg_write, 0);
        check_eq("lu_bubble_pc", id_ex_pc, 0);
        ex_mem_read = 1'b0; ex_dest = 3'd0;
        #1;
        check_eq("lu_stall_clear", stall, 0);
        tick();
        instr = 16'h0000;
        check_eq("lu_op", id_ex_op, 10);
        check_eq("lu_rd", id_ex_rd, 6);
        check_eq("lu_rs", id_ex_rs, 7);
        check_eq("lu_imm", id_ex_imm, 8'h0E);
        check_eq("lu_memrd", id_ex_mem_read, 1);
        check_eq("lu_regwr", id_ex_reg_write, 1);
        check_eq("lu_val1", id_ex_val1, 8'h33);
        check_eq("lu_pc", id_ex_pc, 8'h20);
        tick();
        check_eq("lu_next_addi", id_ex_op, 9);
        check_eq("lu_next_pc", id_ex_pc, 8'h21);

        // Taken branch: R1 = 0, BR R1,+1
        instr = 16'hC041; pc = 8'h30;
        tick();
        instr = 16'h9205; pc = 8'h31;
        #1;
        check_eq("brt_taken", branch_taken, 1);
        check_eq("brt_off", branch_offset_imm, 6'b000001);
        check_eq("brt_stall", stall, 0);
        tick();
        instr = 16'h0000;
        check_eq("brt_ex_op", id_ex_op, 12);
        check_eq("brt_ex_regwr", id_ex_reg_write, 0);
        check_eq("brt_ex_memwr", id_ex_mem_write, 0);
        check_eq("brt_ex_pc", id_ex_pc, 8'h30);
        check_eq("brt_flush_taken", branch_taken, 0);
        check_eq("brt_flush_off", branch_offset_imm, 0);
        tick();
        check_eq("brt_flush_op", id_ex_op, 0);
        check_eq("brt_flush_regwr", id_ex_reg_write, 0);

        // Not-taken branch: R1 = 1, BR R1,-5, then branch hazards
        wb_write(3'd1, 8'h01);
        instr = 16'hC07B; pc = 8'h40;
        tick();
        instr = 16'h0000;
        #1;
        check_eq("brn_taken", branch_taken, 0);
        check_eq("brn_off", branch_offset_imm, 6'b111011);
        ex_dest = 3'd1; ex_reg_write = 1'b1;
        #1;
        check_eq("brh_ex_stall", stall, 1);
        check_eq("brh_ex_taken", branch_taken, 0);
        ex_dest = 3'd0; ex_reg_write = 1'b0;
        mem_dest = 3'd1; mem_reg_write = 1'b1;
        #1;
        check_eq("brh_mem_stall", stall, 1);
        mem_dest = 3'd2;
        #1;
        check_eq("brh_mem_other", stall, 0);
        mem_dest = 3'd0; mem_reg_write = 1'b0;
        tick();
        check_eq("brn_ex_op", id_ex_op, 12);
        check_eq("brn_ex_imm", id_ex_imm, 8'hFB);

        // Write-through bypass: ADD R3,R5,R0 in ID while R5 <- 6
        instr = 16'h1740;
        tick();
        instr = 16'h0000;
        wb_write(3'd5, 8'h06);
        check_eq("byp_op", id_ex_op, 1);
        check_eq("byp_val1", id_ex_val1, 8'h06);
        wb_write(3'd0, 8'hAA);
        // ADD R3,R0,R5: R0 still reads 0, R5 kept 6
        instr = 16'h1628;
        tick();
        instr = 16'h0000;
        tick();
        check_eq("r0_val1", id_ex_val1, 8'h00);
        check_eq("r5_val2", id_ex_val2, 8'h06);

        // ST R5 -> 2(R0): store-data register hazard and store decode
        instr = 16'hBA02; pc = 8'h50;
        tick();
        instr = 16'h0000;
        ex_mem_read = 1'b1; ex_dest = 3'd5;
        #1;
        check_eq("st_lu_stall", stall, 1);
        ex_mem_read = 1'b0; ex_dest = 3'd0;
        tick();
        check_eq("st_memwr", id_ex_mem_write, 1);
        check_eq("st_regwr", id_ex_reg_write, 0);
        check_eq("st_val", id_ex_st_val, 8'h06);
        check_eq("st_imm", id_ex_imm, 8'h02);

        // Reset asserted during a load-use stall
        instr = 16'hADCE; pc = 8'h60;
        tick();
        ex_mem_read = 1'b1; ex_dest = 3'd7;
        #1;
        check_eq("rs_pre_stall", stall, 1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rs_stall", stall, 0);
        check_eq("rs_op", id_ex_op, 0);
        check_eq("rs_pc", id_ex_pc, 0);
        check_eq("rs_val1", id_ex_val1, 0);
        check_eq("rs_off", branch_offset_imm, 0);
        #2;
        rst = 1'b0;
        ex_mem_read = 1'b0; ex_dest = 3'd0;
        instr = 16'h9205; pc = 8'h70;
        tick();
        instr = 16'h0000;
        tick();
        check_eq("post_rst_op", id_ex_op, 9);
        check_eq("post_rst_imm", id_ex_imm, 8'h05);
        check_eq("post_rst_regwr", id_ex_reg_write, 1);
        check_eq("post_rst_pc", id_ex_pc, 8'h70);
        // R7 was cleared by reset: ADD R2,R7,R0 reads 0
        instr = 16'h15C0;
        tick();
        instr = 16'h0000;
        tick();
        check_eq("post_rst_r7", id_ex_val1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
